fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00: address fetched first after reset.
REQ-002 The block SHALL have parameter RAS_DEPTH, default 4: return-address stack entries (used only with RAS_EN).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port pc  output  8  instruction ROM address; the ROM returns data combinationally.
REQ-006 The block SHALL have port rom_data  input  16  ROM word at address pc.
REQ-007 The block SHALL have port stall  input  1  freeze fetch; hold all outputs.
REQ-008 The block SHALL have port redirect  input  1  jump/branch taken.
REQ-009 The block SHALL have port redirect_target  input  8  jump/branch destination.
REQ-010 The block SHALL have port call  input  1  call taken.
REQ-011 The block SHALL have port call_target  input  8  call destination.
REQ-012 The block SHALL have port ret  input  1  return taken.
REQ-013 The block SHALL have port instr  output  16  fetched instruction word.
REQ-014 The block SHALL have port ext_lit  output  16  second word of an extended instruction.
REQ-015 The block SHALL have port instr_valid  output  1  instr/ext_lit hold a complete instruction this cycle.
REQ-016 The block SHALL have port ras_ovf  output  1  sticky: call pushed onto a full stack.
REQ-017 The block SHALL have port ras_unf  output  1  sticky: ret issued on an empty stack.

Function
REQ-018 The block SHALL use states FETCH and EXT.
REQ-019 In FETCH with no control input, the block SHALL load instr <= rom_data, set instr_valid=1 and pc <= pc+1 each cycle (one-cycle latency, pc to instr).
REQ-020 The block SHALL treat rom_data[15:10]==6'b100001 in FETCH as extended: instr <= rom_data, pc <= pc+1, instr_valid=0, next state EXT.
REQ-021 In EXT, the block SHALL load ext_lit <= rom_data, set instr_valid=1 and pc <= pc+1, and return to FETCH.
REQ-022 The block SHALL hold ext_lit at its last value outside EXT.
REQ-023 The block SHALL wrap pc from 8'hFF to 8'h00 without error.
REQ-024 Priority SHALL be: rst > redirect > call > ret > stall > sequential.
REQ-025 On redirect, the block SHALL set pc <= redirect_target, instr_valid=0 for the next cycle (flush) and state FETCH, abandoning any pending EXT.
REQ-026 On call, the block SHALL push the current pc, set pc <= call_target, clear instr_valid and set state FETCH.
REQ-027 On ret, the block SHALL pop to pc, clear instr_valid and set state FETCH.
REQ-028 Simultaneous call and ret SHALL perform call only; ret is dropped without setting any flag.
REQ-029 During stall, pc, instr, ext_lit, instr_valid, state and the stack SHALL hold.
REQ-030 Call when the stack is full SHALL still jump, SHALL not push, SHALL leave stack contents unchanged and SHALL set ras_ovf.
REQ-031 Ret when the stack is empty SHALL set pc <= RESET_PC and SHALL set ras_unf.
REQ-032 ras_ovf and ras_unf SHALL be cleared only by rst.

Reset
REQ-033 While rst=1 the block SHALL set pc=RESET_PC, instr=16'h0000 (NOP), ext_lit=16'h0000, instr_valid=0, state FETCH, stack empty, ras_ovf=0 and ras_unf=0.
REQ-034 rst asserted mid-EXT or mid-stall SHALL abandon the operation; the first fetch after release SHALL be from RESET_PC.

Configuration
REQ-035 The macro RAS_EN SHALL select the return stack.
- Defined: RAS_DEPTH-entry LIFO return stack, behaviour per REQ-026..REQ-032.
- Undefined: no stack storage; call behaves as a redirect to call_target; ret behaves as a redirect to redirect_target; ras_ovf and ras_unf tied to 0.

Verification
REQ-036 Reset then run with a ROM loading 8'h00..8'h06 -> pc 00,01,02,...; instr matches ROM words one cycle later; instr_valid=1 from the second cycle onward.
REQ-037 Extended pair at 8'h0B=16'h8500, 8'h0C=16'hC001 -> one instr_valid pulse with instr=16'h8500 and ext_lit=16'hC001; no valid in the EX0 cycle.
REQ-038 Call (RAS_EN) to 8'h80 from pc=8'h10, then ret -> fetch resumes at 8'h80, then returns to 8'h10; one flush cycle at each transfer.
REQ-039 Stall held 3 cycles at pc=8'h05 -> pc, instr and instr_valid unchanged; the next fetch after release is 8'h05.
REQ-040 Five calls with RAS_DEPTH=4 -> ras_ovf=1 after the fifth; five rets -> four correct returns, then pc=RESET_PC and ras_unf=1.
REQ-041 Run from pc=8'hFF, then redirect and call together (target 8'h20 vs 8'h80) -> pc wraps 8'hFF->8'h00; the simultaneous case goes to 8'h20 with no push.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch front end driving a combinational ROM.
//
// Purpose
//   Presents pc to the ROM and captures the returned word into instr one
//   cycle later. Words whose top six bits are 6'b100001 are extended
//   instructions: the following ROM word is captured into ext_lit, and
//   instr_valid pulses only once the pair is complete. Redirect, call and
//   return transfers flush instr_valid for one cycle.
//
// Configuration
//   RAS_EN (macro): when defined, call/ret use a RAS_DEPTH-entry LIFO return
//   stack with sticky overflow/underflow flags. When undefined, there is no
//   stack. Call jumps to call_target, ret jumps to redirect_target, and the
//   flags read 0.
//
// Ports
//   clk             clock, all state changes on its rising edge
//   rst             synchronous active-high reset
//   pc              ROM address (8 bits)
//   rom_data        ROM word at pc (16 bits)
//   stall           freeze fetch, all outputs hold
//   redirect        jump/branch taken, to redirect_target
//   call            call taken, to call_target
//   ret             return taken
//   instr, ext_lit  fetched instruction word and extension literal
//   instr_valid     instr/ext_lit hold a complete instruction
//   ras_ovf/ras_unf sticky stack overflow/underflow flags
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter int         RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  pc,
  input  logic [15:0] rom_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_target,
  input  logic        call,
  input  logic [7:0]  call_target,
  input  logic        ret,
  output logic [15:0] instr,
  output logic [15:0] ext_lit,
  output logic        instr_valid,
  output logic        ras_ovf,
  output logic        ras_unf
);

  typedef enum logic {FETCH, EXT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ext_lit_q, ext_lit_d;
  logic        instr_valid_q, instr_valid_d;

`ifdef RAS_EN
  localparam int SP_W  = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [7:0]      stack_q [RAS_DEPTH];
  logic [SP_W-1:0] sp_q, sp_d, sp_m1;
  logic            push_en, pop_en, stack_full, stack_empty;
  logic            ras_ovf_q, ras_ovf_d, ras_unf_q, ras_unf_d;
  logic [7:0]      stack_top;

  assign sp_m1       = sp_q - SP_W'(1);
  assign stack_full  = (sp_q == SP_W'(RAS_DEPTH));
  assign stack_empty = (sp_q == '0);
  // Index wraps harmlessly when the stack is empty; it is only used on a pop.
  assign stack_top   = stack_q[sp_m1[IDX_W-1:0]];
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    ext_lit_d     = ext_lit_q;
    instr_valid_d = instr_valid_q;
`ifdef RAS_EN
    push_en   = 1'b0;
    pop_en    = 1'b0;
    ras_ovf_d = ras_ovf_q;
    ras_unf_d = ras_unf_q;
`endif

    if (redirect) begin
      // Redirect wins over call/ret; a call dropped here pushes nothing.
      pc_d          = redirect_target;
      instr_valid_d = 1'b0;
      state_d       = FETCH;
    end else if (call) begin
      // A simultaneous ret is silently dropped.
      pc_d          = call_target;
      instr_valid_d = 1'b0;
      state_d       = FETCH;
`ifdef RAS_EN
      if (stack_full) ras_ovf_d = 1'b1;
      else            push_en   = 1'b1;
`endif
    end else if (ret) begin
      instr_valid_d = 1'b0;
      state_d       = FETCH;
`ifdef RAS_EN
      if (stack_empty) begin
        pc_d      = RESET_PC;
        ras_unf_d = 1'b1;
      end else begin
        pc_d   = stack_top;
        pop_en = 1'b1;
      end
`else
      pc_d = redirect_target;
`endif
    end else if (!stall) begin
      pc_d = pc_q + 8'd1;
      if (state_q == FETCH) begin
        instr_d = rom_data;
        if (rom_data[15:10] == 6'b100001) begin
          instr_valid_d = 1'b0;
          state_d       = EXT;
        end else begin
          instr_valid_d = 1'b1;
        end
      end else begin
        ext_lit_d     = rom_data;
        instr_valid_d = 1'b1;
        state_d       = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= 16'h0000;
      ext_lit_q     <= 16'h0000;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      ext_lit_q     <= ext_lit_d;
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef RAS_EN
  always_comb begin
    sp_d = sp_q;
    if (push_en)     sp_d = sp_q + SP_W'(1);
    else if (pop_en) sp_d = sp_m1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q      <= '0;
      ras_ovf_q <= 1'b0;
      ras_unf_q <= 1'b0;
    end else begin
      sp_q      <= sp_d;
      ras_ovf_q <= ras_ovf_d;
      ras_unf_q <= ras_unf_d;
    end
  end

  // Entries carry no reset; the stack pointer alone defines what is live.
  for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_stack
    always_ff @(posedge clk) begin
      if (!rst && push_en && (sp_q[IDX_W-1:0] == IDX_W'(gi))) begin
        stack_q[gi] <= pc_q;
      end
    end
  end

  assign ras_ovf = ras_ovf_q;
  assign ras_unf = ras_unf_q;
`else
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign ext_lit     = ext_lit_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Each step pushes the expected
// post-edge outputs to a scoreboard, clocks once, then pops and compares.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic [15:0] rom_data;
  logic        stall, redirect, call, ret;
  logic [7:0]  redirect_target, call_target;
  logic [15:0] instr, ext_lit;
  logic        instr_valid, ras_ovf, ras_unf;

  logic [15:0] rom [256];
  int checks = 0;
  int errors = 0;
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [15:0] ext;
    logic        valid;
    logic        ovf;
    logic        unf;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  assign rom_data = rom[pc];

  fetch_sequencer #(.RESET_PC(8'h00), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .rom_data(rom_data), .stall(stall),
    .redirect(redirect), .redirect_target(redirect_target),
    .call(call), .call_target(call_target), .ret(ret),
    .instr(instr), .ext_lit(ext_lit), .instr_valid(instr_valid),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  task automatic step(input logic [7:0] e_pc, input logic [15:0] e_instr,
                      input logic [15:0] e_ext, input logic e_valid, input string tag);
    exp_t e;
    e.pc = e_pc; e.instr = e_instr; e.ext = e_ext; e.valid = e_valid;
    e.ovf = exp_ovf; e.unf = exp_unf; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    redirect = 1'b0; call = 1'b0; ret = 1'b0; stall = 1'b0;
    e = sb_q.pop_front();
    $display("step %-14s pc=%h instr=%h ext=%h v=%b ovf=%b unf=%b", e.tag, pc, instr, ext_lit, instr_valid, ras_ovf, ras_unf);
    checks++;
    assert (pc === e.pc) else begin errors++; $error("FAIL %s pc observed %h expected %h", e.tag, pc, e.pc); end
    checks++;
    assert (instr === e.instr) else begin errors++; $error("FAIL %s instr observed %h expected %h", e.tag, instr, e.instr); end
    checks++;
    assert (ext_lit === e.ext) else begin errors++; $error("FAIL %s ext_lit observed %h expected %h", e.tag, ext_lit, e.ext); end
    checks++;
    assert (instr_valid === e.valid) else begin errors++; $error("FAIL %s instr_valid observed %b expected %b", e.tag, instr_valid, e.valid); end
    checks++;
    assert (ras_ovf === e.ovf) else begin errors++; $error("FAIL %s ras_ovf observed %b expected %b", e.tag, ras_ovf, e.ovf); end
    checks++;
    assert (ras_unf === e.unf) else begin errors++; $error("FAIL %s ras_unf observed %b expected %b", e.tag, ras_unf, e.unf); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
    rom[8'h0B] = 16'h8500;
    rom[8'h0C] = 16'hC001;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; call = 1'b0; ret = 1'b0;
    redirect_target = 8'h00; call_target = 8'h00;

    step(8'h00, 16'h0000, 16'h0000, 1'b0, "reset");
    step(8'h00, 16'h0000, 16'h0000, 1'b0, "reset_hold");
    rst = 1'b0;

    // Sequential run: pc advances, instr is the ROM word one cycle later.
    for (int p = 0; p <= 8'h0A; p++)
      step(8'(p + 1), 16'h1000 | 16'(p), 16'h0000, 1'b1, "seq");

    // Extended pair at 0B/0C.
    step(8'h0C, 16'h8500, 16'h0000, 1'b0, "ext_first");
    step(8'h0D, 16'h8500, 16'hC001, 1'b1, "ext_pair");
    step(8'h0E, 16'h100D, 16'hC001, 1'b1, "ext_hold");

    // Stall at pc 05.
    redirect = 1'b1; redirect_target = 8'h04;
    step(8'h04, 16'h100D, 16'hC001, 1'b0, "redir");
    step(8'h05, 16'h1004, 16'hC001, 1'b1, "pre_stall");
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      step(8'h05, 16'h1004, 16'hC001, 1'b1, "stall");
    end
    step(8'h06, 16'h1005, 16'hC001, 1'b1, "stall_release");

    // Redirect while in EXT abandons the pending extension.
    redirect = 1'b1; redirect_target = 8'h0B;
    step(8'h0B, 16'h1005, 16'hC001, 1'b0, "redir_ext");
    step(8'h0C, 16'h8500, 16'hC001, 1'b0, "enter_ext");
    stall = 1'b1;
    step(8'h0C, 16'h8500, 16'hC001, 1'b0, "stall_in_ext");
    redirect = 1'b1; redirect_target = 8'h30;
    step(8'h30, 16'h8500, 16'hC001, 1'b0, "abandon_ext");
    step(8'h31, 16'h1030, 16'hC001, 1'b1, "after_abandon");

    // pc wrap.
    redirect = 1'b1; redirect_target = 8'hFE;
    step(8'hFE, 16'h1030, 16'hC001, 1'b0, "redir_fe");
    step(8'hFF, 16'h10FE, 16'hC001, 1'b1, "at_ff");
    step(8'h00, 16'h10FF, 16'hC001, 1'b1, "wrap");
    step(8'h01, 16'h1000, 16'hC001, 1'b1, "post_wrap");

`ifdef RAS_EN
    redirect = 1'b1; redirect_target = 8'h10;
    step(8'h10, 16'h1000, 16'hC001, 1'b0, "to_10");
    call = 1'b1; call_target = 8'h80;
    step(8'h80, 16'h1000, 16'hC001, 1'b0, "call_80");
    step(8'h81, 16'h1080, 16'hC001, 1'b1, "in_callee");
    ret = 1'b1;
    step(8'h10, 16'h1080, 16'hC001, 1'b0, "ret_10");
    step(8'h11, 16'h1010, 16'hC001, 1'b1, "after_ret");
    // Five calls into a four-deep stack: pushes 11,50,51,52; fifth overflows.
    for (int i = 0; i < 5; i++) begin
      call = 1'b1; call_target = 8'(8'h50 + i);
      if (i == 4) exp_ovf = 1'b1;
      step(8'(8'h50 + i), 16'h1010, 16'hC001, 1'b0, "call_chain");
    end
    ret = 1'b1; step(8'h52, 16'h1010, 16'hC001, 1'b0, "ret_52");
    ret = 1'b1; step(8'h51, 16'h1010, 16'hC001, 1'b0, "ret_51");
    ret = 1'b1; step(8'h50, 16'h1010, 16'hC001, 1'b0, "ret_50");
    ret = 1'b1; step(8'h11, 16'h1010, 16'hC001, 1'b0, "ret_11");
    ret = 1'b1; exp_unf = 1'b1;
    step(8'h00, 16'h1010, 16'hC001, 1'b0, "ret_underflow");
    step(8'h01, 16'h1000, 16'hC001, 1'b1, "after_unf");
    // Redirect beats call: no push, so the next ret underflows to RESET_PC.
    redirect = 1'b1; redirect_target = 8'h20; call = 1'b1; call_target = 8'h80;
    step(8'h20, 16'h1000, 16'hC001, 1'b0, "redir_call");
    ret = 1'b1;
    step(8'h00, 16'h1000, 16'hC001, 1'b0, "ret_nopush");
`else
    redirect = 1'b1; redirect_target = 8'h20; call = 1'b1; call_target = 8'h80;
    step(8'h20, 16'h1000, 16'hC001, 1'b0, "redir_call");
    call = 1'b1; call_target = 8'h80;
    step(8'h80, 16'h1000, 16'hC001, 1'b0, "call_jump");
    ret = 1'b1; redirect_target = 8'h40;
    step(8'h40, 16'h1000, 16'hC001, 1'b0, "ret_jump");
    call = 1'b1; ret = 1'b1; call_target = 8'h90; redirect_target = 8'h44;
    step(8'h90, 16'h1000, 16'hC001, 1'b0, "call_and_ret");
`endif

    // Reset in the middle of an extended fetch.
    redirect = 1'b1; redirect_target = 8'h0B;
    step(8'h0B, 16'h1000, 16'hC001, 1'b0, "redir_0b");
    step(8'h0C, 16'h8500, 16'hC001, 1'b0, "ext_again");
    rst = 1'b1; exp_ovf = 1'b0; exp_unf = 1'b0;
    step(8'h00, 16'h0000, 16'h0000, 1'b0, "rst_mid_ext");
    rst = 1'b0;
    step(8'h01, 16'h1000, 16'h0000, 1'b1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
